// File: rtl/frame_overlap_buffer.sv
// frame_overlap_buffer
//   Collects a sample stream into a circular buffer of 2*FRAME_LEN entries and
//   replays overlapping frames of FRAME_LEN samples, one new frame every HOP
//   accepted samples. Each frame is emitted as one gap-free burst, oldest
//   sample first, ending with the sample that triggered it.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_data    input sample (opaque bit pattern)
//   in_valid   write enable for in_data; no backpressure
//   out_data   framed sample, registered
//   out_valid  framed sample valid
//   out_first  first sample of a frame
//   out_last   last sample of a frame
//   busy       burst in progress, from first read issue through last sample
//   overflow   sticky: a frame trigger arrived during a burst and was dropped
module frame_overlap_buffer #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned HOP       = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_first,
    output logic              out_last,
    output logic              busy,
    output logic              overflow
);

    localparam int unsigned PTR_W = $clog2(FRAME_LEN) + 1;
    localparam int unsigned DEPTH = 2 * FRAME_LEN;

    localparam logic [PTR_W-1:0] FRAME_LEN_P = PTR_W'(FRAME_LEN);
    localparam logic [PTR_W-1:0] HOP_P       = PTR_W'(HOP);
    localparam logic [PTR_W-1:0] ONE_P       = PTR_W'(1);

    typedef enum logic {
        IDLE,
        READ
    } state_t;

    state_t state, state_next;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_q;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] fill;
    logic [PTR_W-1:0] hop_cnt;
    logic [PTR_W-1:0] burst_cnt;

    logic issue_v;
    logic issue_first;
    logic issue_last;

    logic first_done;
    logic trigger;
    logic start;
    logic drop;
    logic last_issue;

    // Until the first frame, the trigger is fill reaching FRAME_LEN; after
    // that fill stays saturated and hop_cnt takes over.
    always_comb begin
        first_done = (fill == FRAME_LEN_P);
        trigger    = 1'b0;
        if (in_valid) begin
            if (first_done) begin
                trigger = ((hop_cnt + ONE_P) == HOP_P);
            end else begin
                trigger = ((fill + ONE_P) == FRAME_LEN_P);
            end
        end
    end

    // A trigger in the final issue cycle still sees READ and is dropped.
    always_comb begin
        state_next = state;
        last_issue = (state == READ) && (burst_cnt == (FRAME_LEN_P - ONE_P));
        start      = 1'b0;
        drop       = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) begin
                    start      = 1'b1;
                    state_next = READ;
                end
            end
            READ: begin
                drop = trigger;
                if (last_issue) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fill        <= '0;
            hop_cnt     <= '0;
            burst_cnt   <= '0;
            issue_v     <= 1'b0;
            issue_first <= 1'b0;
            issue_last  <= 1'b0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_first   <= 1'b0;
            out_last    <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (in_valid) begin
                wr_ptr <= wr_ptr + ONE_P;
                if (!first_done) begin
                    fill <= fill + ONE_P;
                end
            end

            if (trigger) begin
                hop_cnt <= '0;
            end else if (in_valid && first_done) begin
                hop_cnt <= hop_cnt + ONE_P;
            end

            // wr_ptr still points at the triggering sample's slot here, so
            // +1 - FRAME_LEN lands on the oldest sample of the frame.
            if (start) begin
                rd_ptr    <= wr_ptr + ONE_P - FRAME_LEN_P;
                burst_cnt <= '0;
            end else if (state == READ) begin
                rd_ptr    <= rd_ptr + ONE_P;
                burst_cnt <= burst_cnt + ONE_P;
            end

            // Flags travel alongside the one-cycle BRAM read.
            issue_v     <= (state == READ);
            issue_first <= (state == READ) && (burst_cnt == '0);
            issue_last  <= last_issue;

            out_valid <= issue_v;
            out_first <= issue_first;
            out_last  <= issue_last;
            if (issue_v) begin
                out_data <= ram_q;
            end

            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Buffer storage kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            mem[wr_ptr] <= in_data;
        end
        if (state == READ) begin
            ram_q <= mem[rd_ptr];
        end
    end

    assign busy = (state == READ) | issue_v | out_valid;

endmodule

// File: tb/tb_frame_overlap_buffer.sv
module tb_frame_overlap_buffer;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned FRAME_LEN = 256;
    localparam int unsigned HOP       = 128;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_first;
    logic              out_last;
    logic              busy;
    logic              overflow;

    always #5 clk = ~clk;

    frame_overlap_buffer #(
        .DATA_W(DATA_W),
        .FRAME_LEN(FRAME_LEN),
        .HOP(HOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_first(out_first),
        .out_last(out_last),
        .busy(busy),
        .overflow(overflow)
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              first;
        logic              last;
        longint            cyc;
    } exp_t;

    exp_t              sb[$];
    logic [DATA_W-1:0] hist[$];

    int unsigned tests = 0;
    int unsigned fails = 0;
    longint      cyc = 0;

    // Reference model state
    int unsigned n_acc;
    int unsigned hop_m;
    bit          first_done;
    bit          have_burst;
    bit          ovf_exp;
    longint      last_trig;
    int unsigned first_seen;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        hist.delete();
        n_acc      = 0;
        hop_m      = 0;
        first_done = 0;
        have_burst = 0;
        ovf_exp    = 0;
        last_trig  = 0;
    endtask

    // Sample d is accepted at edge e.
    task automatic model_accept(input longint e, input logic [DATA_W-1:0] d);
        bit   trig;
        exp_t it;
        hist.push_back(d);
        if (hist.size() > FRAME_LEN) hist.delete(0);
        trig = 0;
        if (!first_done) begin
            n_acc++;
            if (n_acc == FRAME_LEN) begin
                first_done = 1;
                trig       = 1;
            end
        end else begin
            hop_m++;
            if (hop_m == HOP) trig = 1;
        end
        if (trig) begin
            hop_m = 0;
            // Reads are issued on edges last_trig+1 .. last_trig+FRAME_LEN.
            if (have_burst && e <= last_trig + FRAME_LEN) begin
                ovf_exp = 1;
            end else begin
                have_burst = 1;
                last_trig  = e;
                for (int k = 0; k < int'(FRAME_LEN); k++) begin
                    it.data  = hist[k];
                    it.first = (k == 0);
                    it.last  = (k == int'(FRAME_LEN) - 1);
                    it.cyc   = e + 2 + k;
                    sb.push_back(it);
                end
            end
        end
    endtask

    task automatic monitor();
        bit   exp_v;
        bit   exp_busy;
        exp_t it;
        exp_v = (sb.size() != 0) && (sb[0].cyc == cyc);
        check("out_valid", 64'(out_valid), 64'(exp_v));
        if (exp_v) begin
            it = sb.pop_front();
            if (out_valid) begin
                check("out_data", 64'(out_data), 64'(it.data));
                check("out_first", 64'(out_first), 64'(it.first));
                check("out_last", 64'(out_last), 64'(it.last));
            end
        end
        if (out_valid && out_first) first_seen++;
        exp_busy = have_burst && (cyc >= last_trig) && (cyc <= last_trig + FRAME_LEN + 1);
        check("busy", 64'(busy), 64'(exp_busy));
        check("overflow", 64'(overflow), 64'(ovf_exp));
    endtask

    // One clock cycle: check outputs of the last edge, drive inputs, advance.
    task automatic tick(input logic v, input logic [DATA_W-1:0] d, input logic r);
        @(negedge clk);
        monitor();
        rst      = r;
        in_valid = v;
        in_data  = d;
        if (r) begin
            model_reset();
        end else if (v) begin
            model_accept(cyc + 1, d);
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic send_slow(input int unsigned lo, input int unsigned hi, input int unsigned base);
        for (int unsigned i = lo; i <= hi; i++) begin
            tick(1'b1, DATA_W'(base + i), 1'b0);
            repeat (3) tick(1'b0, '0, 1'b0);
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 2000 && sb.size() != 0; i++) tick(1'b0, '0, 1'b0);
        repeat (4) tick(1'b0, '0, 1'b0);
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        model_reset();
        first_seen = 0;

        // T1: reset held, everything quiet
        repeat (3) tick(1'b0, '0, 1'b1);
        #1;
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_first", 64'(out_first), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        repeat (10) tick(1'b0, '0, 1'b0);

        // T2 + T3: first frame then one hop
        send_slow(0, 255, 0);
        send_slow(256, 383, 0);
        drain("t3_drain");
        check("t3_bursts", 64'(first_seen), 64'd2);
        check("t3_overflow", 64'(overflow), 64'd0);

        // T4: long stream across the buffer wrap
        repeat (2) tick(1'b0, '0, 1'b1);
        first_seen = 0;
        send_slow(0, 2047, 0);
        drain("t4_drain");
        check("t4_bursts", 64'(first_seen), 64'd15);

        // T5: back-to-back input overruns the burst
        repeat (2) tick(1'b0, '0, 1'b1);
        first_seen = 0;
        for (int unsigned i = 0; i < 600; i++) tick(1'b1, DATA_W'(i), 1'b0);
        #1;
        check("t5_overflow", 64'(overflow), 64'd1);
        send_slow(600, 767, 0);
        drain("t5_drain");

        // T6: reset in the middle of a burst
        repeat (2) tick(1'b0, '0, 1'b1);
        send_slow(0, 255, 32'h0001_0000);
        repeat (98) tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b1);
        #1;
        check("t6_valid_after_rst", 64'(out_valid), 64'd0);
        check("t6_busy_after_rst", 64'(busy), 64'd0);
        first_seen = 0;
        send_slow(0, 255, 32'h0002_0000);
        drain("t6_drain");
        check("t6_bursts", 64'(first_seen), 64'd1);
        check("t6_overflow", 64'(overflow), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
